time_parameter: RTL and testbench
=================================

# time_parameter

Programmable timing-parameter store for the traffic light controller. It holds three 4-bit durations: base green time, extended green time and yellow time. A synchronous programming port updates them. The currently requested duration is presented to the timer/FSM through a read mux selected by `interval`.

## Interface
Parameters:
- `DEF_BASE`, 4'd6: base-green reset/default value.
- `DEF_EXT`, 4'd3: extended-green reset/default value.
- `DEF_YEL`, 4'd2: yellow reset/default value.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `Selector`  in  2  parameter to program: 00 base, 01 extended, 10 yellow, 11 none.
- `Time_value`  in  4  value to program, in seconds.
- `Prog_Sync`  in  1  program strobe, level-sensitive, sampled on `clk`.
- `interval`  in  2  parameter to read: 00 base, 01 extended, 10 yellow, 11 base.
- `value`  out  4  duration of the parameter selected by `interval`.

## Operation
- Storage is three 4-bit registers: `t_base`, `t_ext`, `t_yel`.
- **Reset:** on a rising `clk` with `reset_n`=0, registers load `DEF_BASE`/`DEF_EXT`/`DEF_YEL`. Reset overrides `Prog_Sync`.
- **Programming:**
  - On a rising `clk` with `reset_n`=1 and `Prog_Sync`=1, the register addressed by `Selector` loads `Time_value`.
  - `Selector`=11 writes nothing.
  - Only the addressed register changes; the other two hold.
- **Zero guard:** programming `Time_value`=0 loads that register's default instead of 0. A stored parameter is therefore never 0.
- **Repeated writes:** `Prog_Sync` held high writes every cycle. The last sampled `Time_value`/`Selector` pair wins.
- **Read path:** `value` is a combinational mux of the registers by `interval`. 00→`t_base`, 01→`t_ext`, 10→`t_yel`, 11→`t_base`.
- No arithmetic; widths are 4 bits throughout, with no truncation or extension.

## Timing
- Write latency: a write sampled at edge N is visible on `value` immediately after edge N, if `interval` selects that register.
- There is no write-through to `value` before the edge.
- `interval` changes propagate to `value` combinationally, with no cycle latency.
- Reset value of `value`: after the first reset edge, the default of the register selected by `interval` (6, 3, 2, or 6 for 11). Before any reset edge, register contents are undefined.
- Reset asserted mid-programming: the reset edge wins, and the in-flight write is discarded.
- Simultaneous `Prog_Sync` write and `interval` read of the same register: `value` shows the old value until the edge, the new value after it.

## Structure
- Shared package `tlc_pkg` holds:
  - Selector/interval encodings: `SEL_BASE`=2'b00, `SEL_EXT`=2'b01, `SEL_YEL`=2'b10, `SEL_NONE`=2'b11.
  - Default constants 6/3/2.
  - The 4-bit time type.
- One natural sub-module, `time_param_reg`: a 4-bit register with default parameter, synchronous active-low reset, load enable and zero-guard. It is instantiated three times; the top level adds the write decode and read mux.

## Test plan
- **Reset defaults:** `reset_n`=0 for 2 cycles, then 1; sweep `interval` 00/01/10/11 → `value` = 6, 3, 2, 6.
- **Program extended:** `Selector`=01, `Time_value`=15, `Prog_Sync`=1 for one edge; `interval`=01 → `value`=15 after that edge. `interval`=00 → 6 and `interval`=10 → 2, both unchanged.
- **Zero guard:** program yellow to 9, then `Selector`=10, `Time_value`=0, `Prog_Sync`=1 → `t_yel` returns to 2. `interval`=10 shows 9 then 2.
- **Level strobe:** `Prog_Sync` held high, `Selector`=00, `Time_value` stepping 4, 5, 7 on successive cycles → `value` (`interval`=00) tracks 4, 5, 7, one per edge. `Selector`=11 with `Prog_Sync`=1 → no register changes.
- **Reset priority:** `reset_n`=0 and `Prog_Sync`=1 (`Selector`=00, `Time_value`=12) on the same edge → `t_base`=6, not 12.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: parameter encodings,
// default durations and the 4-bit time type.
package tlc_pkg;

    typedef logic [3:0] time_t;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam time_t DEF_BASE_T = 4'd6;
    localparam time_t DEF_EXT_T  = 4'd3;
    localparam time_t DEF_YEL_T  = 4'd2;

endpackage

// File: rtl/time_param_reg.sv
// One stored duration: loads on enable, falls back to its default on reset
// or when programmed with zero, so the stored value is never 0.
module time_param_reg #(
    parameter logic [3:0] DEF = 4'd6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= DEF;
        end else if (load) begin
            q <= (din == 4'd0) ? DEF : din;
        end
    end

endmodule

// File: rtl/time_parameter.sv
// Programmable timing-parameter store: three duration registers with a
// synchronous programming port and a combinational read mux.
module time_parameter
    import tlc_pkg::*;
#(
    parameter logic [3:0] DEF_BASE = tlc_pkg::DEF_BASE_T,
    parameter logic [3:0] DEF_EXT  = tlc_pkg::DEF_EXT_T,
    parameter logic [3:0] DEF_YEL  = tlc_pkg::DEF_YEL_T
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Selector,
    input  logic [3:0] Time_value,
    input  logic       Prog_Sync,
    input  logic [1:0] interval,
    output logic [3:0] value
);

    time_t t_base, t_ext, t_yel;
    logic  ld_base, ld_ext, ld_yel;

    // SEL_NONE leaves all three load enables low
    assign ld_base = Prog_Sync && (Selector == SEL_BASE);
    assign ld_ext  = Prog_Sync && (Selector == SEL_EXT);
    assign ld_yel  = Prog_Sync && (Selector == SEL_YEL);

    time_param_reg #(.DEF(DEF_BASE)) u_base (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ld_base),
        .din     (Time_value),
        .q       (t_base)
    );

    time_param_reg #(.DEF(DEF_EXT)) u_ext (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ld_ext),
        .din     (Time_value),
        .q       (t_ext)
    );

    time_param_reg #(.DEF(DEF_YEL)) u_yel (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ld_yel),
        .din     (Time_value),
        .q       (t_yel)
    );

    always_comb begin
        value = t_base;
        case (interval)
            SEL_EXT: value = t_ext;
            SEL_YEL: value = t_yel;
            default: value = t_base;
        endcase
    end

endmodule

// File: tb/tb_time_parameter.sv
// Directed bench for time_parameter: expected durations are queued as each
// step is driven and compared against value once it has settled.
module tb_time_parameter;

    logic       clk;
    logic       reset_n;
    logic [1:0] Selector;
    logic [3:0] Time_value;
    logic       Prog_Sync;
    logic [1:0] interval;
    logic [3:0] value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];

    time_parameter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Selector   (Selector),
        .Time_value (Time_value),
        .Prog_Sync  (Prog_Sync),
        .interval   (interval),
        .value      (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [1:0] iv, input logic [3:0] exp, input string tag);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        interval = iv;
        #1;
        got = sb.pop_front();
        checks++;
        assert (value === got.exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", got.tag, value, got.exp);
        end
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] tv);
        Selector   = sel;
        Time_value = tv;
        Prog_Sync  = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        Selector   = 2'b00;
        Time_value = 4'd0;
        Prog_Sync  = 1'b0;
        interval   = 2'b00;
        step();
        step();
        reset_n = 1'b1;
        chk(2'b00, 4'd6, "reset_base");
        chk(2'b01, 4'd3, "reset_ext");
        chk(2'b10, 4'd2, "reset_yel");
        chk(2'b11, 4'd6, "reset_sel11");

        // program extended; no write-through before the edge
        prog(2'b01, 4'd15);
        chk(2'b01, 4'd3, "ext_before_edge");
        step();
        Prog_Sync = 1'b0;
        chk(2'b01, 4'd15, "ext_after_edge");
        chk(2'b00, 4'd6, "base_untouched");
        chk(2'b10, 4'd2, "yel_untouched");

        // zero guard on yellow
        prog(2'b10, 4'd9);
        step();
        Prog_Sync = 1'b0;
        chk(2'b10, 4'd9, "yel_nine");
        prog(2'b10, 4'd0);
        step();
        Prog_Sync = 1'b0;
        chk(2'b10, 4'd2, "yel_zero_guard");
        chk(2'b01, 4'd15, "ext_held");

        // level strobe: one write per edge
        prog(2'b00, 4'd4);
        step();
        chk(2'b00, 4'd4, "level_4");
        Time_value = 4'd5;
        step();
        chk(2'b00, 4'd5, "level_5");
        Time_value = 4'd7;
        step();
        chk(2'b00, 4'd7, "level_7");
        prog(2'b11, 4'd1);
        step();
        Prog_Sync = 1'b0;
        chk(2'b00, 4'd7, "none_base");
        chk(2'b01, 4'd15, "none_ext");
        chk(2'b10, 4'd2, "none_yel");
        chk(2'b11, 4'd7, "sel11_reads_base");

        // zero guard on extended
        prog(2'b01, 4'd0);
        step();
        Prog_Sync = 1'b0;
        chk(2'b01, 4'd3, "ext_zero_guard");

        // reset overrides a simultaneous write
        prog(2'b01, 4'd11);
        step();
        prog(2'b00, 4'd12);
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        Prog_Sync = 1'b0;
        chk(2'b00, 4'd6, "reset_priority_base");
        chk(2'b01, 4'd3, "reset_priority_ext");
        chk(2'b10, 4'd2, "reset_priority_yel");

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
